// File: rtl/sccb_pkg.sv
// Shared state encoding, ROM markers and small helpers for the SCCB configuration sequencer.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE, PWRUP, FETCH, DECODE, START, XFER, GAP, DELAY, DONE
  } state_e;

  localparam logic [15:0] END_MARK     = 16'hFFFF;
  localparam logic [15:0] DLY_MARK     = 16'hFFF0;
  localparam logic [7:0]  SLAVE_ID_DEF = 8'h42;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// OV7670 register table as a synchronous-read case ROM of {reg_addr, reg_data} entries.
module ov7670_cfg_rom
  import sccb_pkg::*;
#(
  parameter int ROM_AW = 8
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  logic [31:0] addr_ext;
  assign addr_ext = 32'(addr);

  // NOTE: a ROM output register carries no reset; the sequencer never decodes it before a fetch.
  always_ff @(posedge clk) begin
    case (addr_ext)
      32'd0:   data <= 16'h1280;  // COM7: register soft reset, needs the delay that follows
      32'd1:   data <= DLY_MARK;
      32'd2:   data <= 16'h1101;  // CLKRC: input clock divided by 2
      default: data <= END_MARK;
    endcase
  end

endmodule

// File: rtl/sccb_cfg_seq.sv
// Walks the OV7670 configuration ROM and drives the SCCB byte master for each 3-byte write.
// Define SCCB_CFG_RETRY_EN to retry a NACKed entry up to three attempts before abandoning it.
module sccb_cfg_seq
  import sccb_pkg::*;
#(
  parameter logic [7:0] SLAVE_ID  = SLAVE_ID_DEF,
  parameter int         PWRUP_CYC = 100_000,
  parameter int         DELAY_CYC = 1_000_000,
  parameter int         GAP_CYC   = 1_000,
  parameter int         ROM_AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              mst_start,
  output logic              mst_stop,
  output logic [7:0]        mst_wr_data,
  input  logic [1:0]        mst_ack,
  input  logic [3:0]        mst_state,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_cnt,
  output logic [ROM_AW-1:0] entry_idx
);

  localparam int CNT_W = $clog2(max3(PWRUP_CYC, DELAY_CYC, GAP_CYC) + 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

`ifdef SCCB_CFG_RETRY_EN
  localparam int MAX_TRIES = 3;
`else
  localparam int MAX_TRIES = 1;
`endif
  localparam logic [1:0] LAST_TRY = 2'(MAX_TRIES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROM_AW-1:0]   idx_q, idx_d;
  logic [1:0]          phase_q, phase_d;
  logic [1:0]          tries_q, tries_d;
  logic [7:0]          err_q, err_d;
  logic [15:0]         entry_q, entry_d;
  logic [15:0]         rom_data;
  logic                bus_idle;

  assign bus_idle = (mst_state == 4'd0);

  ov7670_cfg_rom #(.ROM_AW(ROM_AW)) u_rom (
    .clk  (clk),
    .addr (idx_q),
    .data (rom_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      phase_q <= 2'd0;
      tries_q <= 2'd0;
      err_q   <= 8'd0;
      entry_q <= 16'd0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      tries_q <= tries_d;
      err_q   <= err_d;
      entry_q <= entry_d;
    end
  end

  // NOTE: every variable gets its default first, so no path can leave one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    tries_d = tries_q;
    err_d   = err_q;
    entry_d = entry_q;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          idx_d   = '0;
          err_d   = 8'd0;
          tries_d = 2'd0;
          cnt_d   = '0;
          state_d = PWRUP;
        end
      end
      PWRUP: begin
        if (cnt_q == PWRUP_LAST) state_d = FETCH;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        entry_d = rom_data;
        if (rom_data == END_MARK) begin
          state_d = DONE;
        end else if (rom_data == DLY_MARK) begin
          idx_d   = idx_q + ROM_AW'(1);
          tries_d = 2'd0;
          cnt_d   = '0;
          state_d = DELAY;
        end else begin
          state_d = START;
        end
      end
      START: begin
        if (bus_idle) begin
          phase_d = 2'd1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (mst_ack[1]) begin
          if (mst_ack[0] && phase_q != 2'd3) begin
            phase_d = phase_q + 2'd1;
          end else begin
            // Entry finishes on a full ACK or on its last permitted NACK; otherwise it is retried.
            if (mst_ack[0] || tries_q == LAST_TRY) begin
              idx_d   = idx_q + ROM_AW'(1);
              tries_d = 2'd0;
              if (!mst_ack[0]) err_d = sat_inc8(err_q);
            end else begin
              tries_d = tries_q + 2'd1;
            end
            cnt_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q != GAP_LAST) cnt_d   = cnt_q + CNT_W'(1);
        else if (bus_idle)     state_d = FETCH;
      end
      DELAY: begin
        if (cnt_q == DELAY_LAST) state_d = FETCH;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Start exists only in START, so the master never sees a repeated start at an ack tick.
  always_comb begin
    mst_start   = (state_q == START) && bus_idle;
    mst_stop    = 1'b0;
    mst_wr_data = SLAVE_ID;
    busy        = (state_q != IDLE) && (state_q != DONE);
    done        = (state_q == DONE);
    if (state_q == XFER) begin
      mst_stop    = (phase_q == 2'd3) || (mst_ack[1] && !mst_ack[0]);
      mst_wr_data = (phase_q == 2'd1) ? entry_q[15:8] : entry_q[7:0];
    end
  end

  assign err_cnt   = err_q;
  assign entry_idx = idx_q;

endmodule
